time_set_ctrl: RTL

- Upstream user-input stage for the alarm clock. It converts the raw board buttons into the current-time preset and the alarm preset that the alarm core consumes.
- Debounces four buttons and runs a mode FSM (RUN / SET_TIME / SET_ALARM). In the set modes the user edits one BCD digit at a time.
- On leaving SET_TIME it issues a one-cycle load strobe with the new time. On leaving SET_ALARM it commits the alarm time.

---
 rtl/time_set_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Alarm-clock user-input stage: debounces four buttons and runs the
// RUN / SET_TIME / SET_ALARM mode FSM that edits the time and alarm presets.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   btn_mode/next/up/down         raw asynchronous buttons
//   *_now                         current time from the clock core (BCD)
//   *_init, time_load             time preset and its one-cycle load strobe
//   *_bud, bud_en                 committed alarm time and alarm enable
//   mode, digit_sel, edit_digits  FSM mode, edited digit and edit register
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] hourdec_now,
    input  logic [3:0] hourone_now,
    input  logic [3:0] mindec_now,
    input  logic [3:0] minone_now,
    output logic [3:0] hourdec_init,
    output logic [3:0] hourone_init,
    output logic [3:0] mindec_init,
    output logic [3:0] minone_init,
    output logic       time_load,
    output logic [3:0] hourdec_bud,
    output logic [3:0] hourone_bud,
    output logic [3:0] mindec_bud,
    output logic [3:0] minone_bud,
    output logic       bud_en,
    output logic [1:0] mode,
    output logic [1:0] digit_sel,
    output logic [15:0] edit_digits
);

    localparam int unsigned NBTN  = 4;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        BAD       = 2'd3
    } mode_t;

    // Bit 3 = mode, 2 = next, 1 = up, 0 = down
    logic [NBTN-1:0]  raw, sync1, sync2, level, press;
    logic [CNT_W-1:0] cnt [NBTN];

    assign raw = {btn_mode, btn_next, btn_up, btn_down};

    // Synchronizer, debouncer and rising-edge press pulse per button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NBTN; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                    press[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Fixed priority: mode > next > up > down, losers are dropped
    logic p_mode, p_next, p_up, p_down;
    assign p_mode = press[3];
    assign p_next = press[2] & ~press[3];
    assign p_up   = press[1] & ~(|press[3:2]);
    assign p_down = press[0] & ~(|press[3:1]);

    function automatic logic [3:0] inc_wrap(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? 4'd0 : v + 4'd1;
    endfunction

    // Out-of-range values decrement to the range max
    function automatic logic [3:0] dec_wrap(input logic [3:0] v, input logic [3:0] max);
        return (v == 4'd0 || v > max) ? max : v - 4'd1;
    endfunction

    function automatic logic [15:0] digit_edit(input logic [15:0] e, input logic [1:0] sel,
                                               input logic up);
        logic [3:0] hd, ho, md, mo, ho_max;
        hd = e[15:12];
        ho = e[11:8];
        md = e[7:4];
        mo = e[3:0];
        ho_max = (hd == 4'd2) ? 4'd3 : 4'd9;
        case (sel)
            2'd0: begin
                hd = up ? inc_wrap(hd, 4'd2) : dec_wrap(hd, 4'd2);
                // Entering the 20s pulls an out-of-range hour unit down to 3
                if (hd == 4'd2 && ho > 4'd3) ho = 4'd3;
            end
            2'd1:    ho = up ? inc_wrap(ho, ho_max) : dec_wrap(ho, ho_max);
            2'd2:    md = up ? inc_wrap(md, 4'd5) : dec_wrap(md, 4'd5);
            default: mo = up ? inc_wrap(mo, 4'd9) : dec_wrap(mo, 4'd9);
        endcase
        return {hd, ho, md, mo};
    endfunction

    mode_t       state_q, state_d;
    logic [15:0] edit_q, edit_d, init_q, init_d, bud_q, bud_d;
    logic [1:0]  ds_q, ds_d;
    logic        bud_en_q, bud_en_d, load_q, load_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            edit_q   <= '0;
            init_q   <= '0;
            bud_q    <= '0;
            ds_q     <= '0;
            bud_en_q <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            edit_q   <= edit_d;
            init_q   <= init_d;
            bud_q    <= bud_d;
            ds_q     <= ds_d;
            bud_en_q <= bud_en_d;
            load_q   <= load_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        edit_d   = edit_q;
        init_d   = init_q;
        bud_d    = bud_q;
        ds_d     = ds_q;
        bud_en_d = bud_en_q;
        load_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (p_mode) begin
                    state_d = SET_TIME;
                    edit_d  = {hourdec_now, hourone_now, mindec_now, minone_now};
                    ds_d    = 2'd0;
                end else if (p_up) begin
                    bud_en_d = ~bud_en_q;
                end
            end
            SET_TIME, SET_ALARM: begin
                if (p_mode) begin
                    if (state_q == SET_TIME) begin
                        state_d = SET_ALARM;
                        init_d  = edit_q;
                        load_d  = 1'b1;
                        edit_d  = bud_q;
                        ds_d    = 2'd0;
                    end else begin
                        state_d = RUN;
                        bud_d   = edit_q;
                    end
                end else if (p_next) begin
                    ds_d = ds_q + 2'd1;
                end else if (p_up || p_down) begin
                    edit_d = digit_edit(edit_q, ds_q, p_up);
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign {hourdec_init, hourone_init, mindec_init, minone_init} = init_q;
    assign {hourdec_bud, hourone_bud, mindec_bud, minone_bud}     = bud_q;
    assign time_load   = load_q;
    assign bud_en      = bud_en_q;
    assign mode        = state_q;
    assign digit_sel   = ds_q;
    assign edit_digits = edit_q;

endmodule
